// File: rtl/sha256_job_arbiter_if.sv
// Signal bundle between the job sources, the arbiter and the shared SHA-256 engine.
interface sha256_job_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0][15:0]   req_msg_addr;
  logic [NUM_REQ-1:0][15:0]   req_out_addr;
  logic [NUM_REQ-1:0]         ack;
  logic [NUM_REQ-1:0]         err;
  logic                       eng_start;
  logic [15:0]                eng_message_addr;
  logic [15:0]                eng_output_addr;
  logic                       eng_done;
  logic                       busy;
  logic [IDW-1:0]             grant_id;
  logic [15:0]                job_count;

  modport slave (
    input  req, req_msg_addr, req_out_addr, eng_done,
    output ack, err, eng_start, eng_message_addr, eng_output_addr,
           busy, grant_id, job_count
  );

  modport master (
    output req, req_msg_addr, req_out_addr, eng_done,
    input  ack, err, eng_start, eng_message_addr, eng_output_addr,
           busy, grant_id, job_count
  );
endinterface

// File: rtl/sha256_job_arbiter.sv
// Round-robin job arbiter sharing one SHA-256 engine among NUM_REQ requesters,
// with a bounded wait on the engine and one-cycle ack/err responses.
module sha256_job_arbiter_lane (
  input  logic clk,
  input  logic reset_n,
  input  logic hit,
  input  logic set_ack,
  input  logic set_err,
  output logic ack,
  output logic err
);
  // Pulses are re-evaluated every cycle, so they self-clear in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack <= 1'b0;
      err <= 1'b0;
    end else begin
      ack <= hit & set_ack;
      err <= hit & set_err;
    end
  end
endmodule

module sha256_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sha256_job_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int TCW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;

  typedef struct packed {
    logic [15:0] msg;
    logic [15:0] out;
  } job_t;

  logic [2:0]         state;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     gid;
  logic [TCW-1:0]     tcnt;
  logic               start;
  logic               busy_q;
  logic [15:0]        jcnt;
  job_t               job;

  logic               found;
  logic [IDW-1:0]     winner;
  logic [IDW:0]       scan;
  logic               timeout;
  logic               set_ack;
  logic               set_err;
  logic [NUM_REQ-1:0] ack_v;
  logic [NUM_REQ-1:0] err_v;

  // First set req bit at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    scan   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ)) scan = scan - (IDW+1)'(NUM_REQ);
      if (!found && bus.req[scan[IDW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IDW-1:0];
      end
    end
  end

  assign timeout = (tcnt == TCW'(TIMEOUT_CYCLES - 1));
  assign set_ack = (state == S_WAIT_DONE) && bus.eng_done;
  // Completion beats a coincident timeout; WAIT_BUSY has no completion path.
  assign set_err = timeout && ((state == S_WAIT_BUSY) ||
                               (state == S_WAIT_DONE && !bus.eng_done));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      gid    <= '0;
      tcnt   <= '0;
      start  <= 1'b0;
      busy_q <= 1'b0;
      jcnt   <= '0;
      job    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // eng_done gate also blocks a new start while an abandoned job still runs.
          if (bus.eng_done && found) begin
            job.msg <= bus.req_msg_addr[winner];
            job.out <= bus.req_out_addr[winner];
            gid     <= winner;
            start   <= 1'b1;
            busy_q  <= 1'b1;
            tcnt    <= '0;
            ptr     <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start <= 1'b0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (timeout) begin
            state <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
            if (!bus.eng_done) state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (bus.eng_done) begin
            jcnt  <= jcnt + 16'd1;
            state <= S_RESP;
          end else if (timeout) begin
            state <= S_RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_RESP: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    sha256_job_arbiter_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .hit     (gid == IDW'(i)),
      .set_ack (set_ack),
      .set_err (set_err),
      .ack     (ack_v[i]),
      .err     (err_v[i])
    );
  end

  assign bus.ack              = ack_v;
  assign bus.err              = err_v;
  assign bus.eng_start        = start;
  assign bus.eng_message_addr = job.msg;
  assign bus.eng_output_addr  = job.out;
  assign bus.busy             = busy_q;
  assign bus.grant_id         = gid;
  assign bus.job_count        = jcnt;
endmodule

// File: tb/tb_sha256_job_arbiter.sv
// Directed scoreboard bench: dut_a uses the default timeout, dut_b a 16-cycle timeout.
module tb_sha256_job_arbiter;
  typedef struct {
    int          id;
    logic [15:0] m;
    logic [15:0] o;
    bit          is_err;
    int          lat;
  } exp_t;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic            sel_b   = 1'b0;
  logic [3:0]      req     = '0;
  logic [3:0][15:0] msg;
  logic [3:0][15:0] out;
  int  lat    = 20;
  bit  ignore = 1'b0;
  int  cnt_a  = 0;
  int  cnt_b  = 0;
  int  cyc    = 0;
  int  nchk   = 0;
  int  nerr   = 0;
  int  t_start = 0;
  exp_t sbq[$];
  exp_t cur;

  sha256_job_arbiter_if #(.NUM_REQ(4)) ifa ();
  sha256_job_arbiter_if #(.NUM_REQ(4)) ifb ();

  assign ifa.req          = sel_b ? 4'b0 : req;
  assign ifb.req          = sel_b ? req : 4'b0;
  assign ifa.req_msg_addr = msg;
  assign ifb.req_msg_addr = msg;
  assign ifa.req_out_addr = out;
  assign ifb.req_out_addr = out;
  assign ifa.eng_done     = (cnt_a == 0);
  assign ifb.eng_done     = (cnt_b == 0);

  sha256_job_arbiter #(.NUM_REQ(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );
  sha256_job_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: samples start on the edge, then holds done low for `lat` cycles.
  always @(posedge clk) begin
    if (cnt_a > 0) cnt_a <= cnt_a - 1;
    else if (ifa.eng_start && !ignore) cnt_a <= lat;
    if (cnt_b > 0) cnt_b <= cnt_b - 1;
    else if (ifb.eng_start && !ignore) cnt_b <= lat;
  end

  wire        v_st   = sel_b ? ifb.eng_start        : ifa.eng_start;
  wire [3:0]  v_ack  = sel_b ? ifb.ack              : ifa.ack;
  wire [3:0]  v_err  = sel_b ? ifb.err              : ifa.err;
  wire        v_busy = sel_b ? ifb.busy             : ifa.busy;
  wire [1:0]  v_gid  = sel_b ? ifb.grant_id         : ifa.grant_id;
  wire [15:0] v_jc   = sel_b ? ifb.job_count        : ifa.job_count;
  wire [15:0] v_ma   = sel_b ? ifb.eng_message_addr : ifa.eng_message_addr;
  wire [15:0] v_oa   = sel_b ? ifb.eng_output_addr  : ifa.eng_output_addr;
  wire        v_done = sel_b ? ifb.eng_done         : ifa.eng_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input bit is_err, input int l);
    exp_t e;
    e.id = id; e.m = msg[id]; e.o = out[id]; e.is_err = is_err; e.lat = l;
    sbq.push_back(e);
  endtask

  task automatic wait_grant(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (v_st) begin ok = 1'b1; break; end
    end
    chk({tag, " start seen"}, 32'(ok), 32'd1);
    chk({tag, " queued"}, 32'(sbq.size() > 0), 32'd1);
    if (!ok || sbq.size() == 0) return;
    cur = sbq.pop_front();
    t_start = cyc;
    chk({tag, " grant_id"}, 32'(v_gid), 32'(cur.id));
    chk({tag, " msg_addr"}, 32'(v_ma), 32'(cur.m));
    chk({tag, " out_addr"}, 32'(v_oa), 32'(cur.o));
    chk({tag, " busy"}, 32'(v_busy), 32'd1);
    @(negedge clk);
    chk({tag, " start one cycle"}, 32'(v_st), 32'd0);
  endtask

  task automatic wait_resp(input string tag);
    bit ok = 1'b0;
    logic [3:0] oh;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (|(v_ack | v_err)) begin ok = 1'b1; break; end
    end
    chk({tag, " resp seen"}, 32'(ok), 32'd1);
    if (!ok) return;
    oh = 4'b0001 << cur.id;
    chk({tag, " ack"}, 32'(v_ack), 32'(cur.is_err ? 4'b0 : oh));
    chk({tag, " err"}, 32'(v_err), 32'(cur.is_err ? oh : 4'b0));
    chk({tag, " latency"}, 32'(cyc - t_start), 32'(cur.lat));
    chk({tag, " addr held"}, 32'(v_ma), 32'(cur.m));
    req[cur.id] = 1'b0;
    @(negedge clk);
    chk({tag, " pulse cleared"}, 32'({v_ack, v_err}), 32'd0);
    chk({tag, " busy low"}, 32'(v_busy), 32'd0);
  endtask

  initial begin
    bit early;
    int tdone;
    int s3;
    int t;
    for (int i = 0; i < 4; i++) begin
      msg[i] = 16'h1000 + 16'(i);
      out[i] = 16'h2000 + 16'(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset a outs", 32'({ifa.ack, ifa.err, ifa.eng_start, ifa.busy, ifa.grant_id}), 32'd0);
    chk("reset a count", 32'(ifa.job_count), 32'd0);
    chk("reset a addr", 32'({ifa.eng_message_addr, ifa.eng_output_addr}), 32'd0);
    chk("reset b outs", 32'({ifb.ack, ifb.err, ifb.eng_start, ifb.busy, ifb.grant_id}), 32'd0);
    reset_n = 1'b1;

    // Contention from ptr=0: order 0,1,3, then a late req[0]
    lat = 20;
    push(0, 0, 22); push(1, 0, 22); push(3, 0, 22);
    req = 4'b1011;
    wait_grant("c0"); wait_resp("c0");
    wait_grant("c1"); wait_resp("c1");
    wait_grant("c3");
    req[0] = 1'b1; push(0, 0, 22);
    wait_resp("c3");
    wait_grant("c0b"); wait_resp("c0b");
    // ptr must now be 1: with req 0 and 1 both up, 1 wins
    push(1, 0, 22); push(0, 0, 22);
    req = 4'b0011;
    wait_grant("p1"); wait_resp("p1");
    wait_grant("p0"); wait_resp("p0");
    chk("contention count", 32'(v_jc), 32'd6);

    // Single long job
    msg[2] = 16'h0010; out[2] = 16'h0100;
    lat = 165;
    push(2, 0, 167);
    req[2] = 1'b1;
    wait_grant("single"); wait_resp("single");
    chk("single count", 32'(v_jc), 32'd7);

    // Fairness wrap from ptr=3
    lat = 20;
    push(3, 0, 22); push(0, 0, 22);
    req = 4'b1001;
    wait_grant("w3"); wait_resp("w3");
    wait_grant("w0"); wait_resp("w0");
    chk("wrap count", 32'(v_jc), 32'd9);

    // Timeout with an engine that never leaves idle
    sel_b = 1'b1; ignore = 1'b1;
    push(1, 1, 17);
    req[1] = 1'b1;
    wait_grant("to1"); wait_resp("to1");
    chk("timeout count", 32'(v_jc), 32'd0);
    push(2, 1, 17);
    req[2] = 1'b1; t = cyc;
    wait_grant("to2");
    chk("regrant latency", 32'(t_start - t), 32'd1);
    wait_resp("to2");

    // Stuck engine: busy 40 cycles, next request waits for done
    ignore = 1'b0; lat = 40;
    push(3, 1, 17);
    req[3] = 1'b1;
    wait_grant("s3"); s3 = t_start;
    req[0] = 1'b1; push(0, 0, 7);
    wait_resp("s3");
    lat = 5;
    wait_grant("s0");
    chk("stuck regrant cycle", 32'(t_start - s3), 32'd42);
    wait_resp("s0");
    chk("stuck count", 32'(v_jc), 32'd1);

    // Reset mid-job while the engine is busy
    sel_b = 1'b0; lat = 100;
    push(1, 0, 102);
    req[1] = 1'b1;
    wait_grant("r1");
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async reset outs", 32'({v_ack, v_err, v_st, v_busy, v_gid}), 32'd0);
    chk("async reset count", 32'(v_jc), 32'd0);
    chk("async reset addr", 32'({v_ma, v_oa}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    lat = 10;
    push(1, 0, 12);
    early = 1'b0; tdone = -1;
    for (int i = 0; i < 300; i++) begin
      if (v_st) early = 1'b1;
      if (v_done) begin tdone = cyc; break; end
      @(negedge clk);
    end
    chk("no start while busy", 32'(early), 32'd0);
    chk("engine returned", 32'(tdone >= 0), 32'd1);
    wait_grant("r1b");
    chk("post reset grant", 32'(t_start - tdone), 32'd1);
    wait_resp("r1b");
    chk("post reset count", 32'(v_jc), 32'd1);

    chk("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
